note_spawner: RTL and testbench
===============================

# note_spawner

Game-side consumer of the level selection handshake. Once the selector raises `level_valid` with a one-hot `level`, it latches the difficulty and derives a spawn period and a note count: easy ×1 speed with 8 notes, mid ×2 with 12, hard ×4 with 16. It then issues that many note-spawn requests on a valid/ready interface toward the note renderer, with lanes chosen pseudo-randomly. It sits between level selection and the play-field logic in the game manager.

## Interface

Parameters:
- `BASE_PERIOD`, default 16'd50000: clock cycles between spawns at ×1 speed. Must be ≥ 4.
- `LFSR_SEED`, default 8'hA5: lane LFSR reset value. Must be nonzero.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset. It has priority over every other input.
- `level_valid`  in  1: selection complete. This is a level signal and stays high until the selector is reset.
- `level`  in  3: {hard, mid, easy}, one-hot. Sampled only on the capture edge.
- `spawn_ready`  in  1: downstream accepts the current spawn.
- `spawn_valid`  out  1: spawn request pending.
- `spawn_lane`  out  2: lane 0–3 of the pending note.
- `spawn_index`  out  5: note number, 0 to total−1.
- `active`  out  1: a run is in progress (WAIT or SPAWN state).
- `done`  out  1: all notes have been handed off. Sticky until `rst`.
- `level_error`  out  1: an invalid level code was captured. Sticky until `rst`.

## Operation

- States: IDLE, WAIT, SPAWN, DONE. Reset state is IDLE.
- Reset values: all outputs 0; LFSR = `LFSR_SEED`; count = 0; timer = 0.

**IDLE**
- If `level_valid`=1 on an edge, that edge is the capture edge, and `level` is sampled there.
- Valid codes:
  - 3'b001: P = BASE_PERIOD, total = 8.
  - 3'b010: P = BASE_PERIOD>>1, total = 12.
  - 3'b100: P = BASE_PERIOD>>2, total = 16.
- On a valid code: go to WAIT, load timer = P−1, count = 0.
- Any other code (000, 011, 101, 110, 111):
  - set `level_error`=1 and stay in IDLE;
  - no further capture happens until `rst`.

**WAIT**
- If timer==0, go to SPAWN; otherwise decrement the timer.

**SPAWN**
- `spawn_valid`=1, `spawn_lane`=LFSR[1:0], `spawn_index`=count.
- All three are held stable until a handshake (`spawn_valid` & `spawn_ready` at an edge).
- On the handshake:
  - count += 1;
  - the LFSR advances one step;
  - if the new count == total, go to DONE; otherwise go to WAIT with timer = P−1.

**DONE**
- `done`=1, `active`=0, `spawn_valid`=0.
- Remains here until `rst`, even though `level_valid` stays high.

**LFSR**
- 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
- Shift left; the new bit 0 is the XOR of bits 7, 5, 4, 3.
- It never reaches zero from a nonzero seed.

**Widths**
- P and timer: 16 bits.
- count and total: 5 bits.
- No overflow is possible within the parameter constraints.

**Ignored inputs**
- Changes on `level` after the capture edge.
- `level_valid` falling during a run.

## Timing

- Capture edge E0: the state is WAIT after E0. `active`=1 from the cycle after E0.
- The first `spawn_valid` rises after edge E0+P.
- Spawn spacing with `spawn_ready` held at 1:
  - valid is high for exactly 1 cycle per note;
  - consecutive rising edges of `spawn_valid` are P+1 cycles apart.
- Back-pressure: the timer does not run in SPAWN. A stall of S cycles delays all later spawns by S.
- Final handshake at edge Ef: `done`=1 and `active`=0 from the cycle after Ef.
- `rst` at any edge, in any state:
  - all outputs read 0 in the next cycle;
  - a pending spawn is dropped, not completed.
- Restart after `rst`: if `level_valid` is already high on the first edge after `rst` deasserts, that edge is a capture edge.
- Determinism: the lane sequence is identical for every run, because the LFSR is reseeded by `rst`.

## Test plan

All scenarios use `BASE_PERIOD`=8.

1. Easy run: `level`=001, `level_valid` rises, `spawn_ready`=1.
   - First `spawn_valid` 8 cycles after capture, then every 9 cycles.
   - `spawn_index` runs 0..7; exactly 8 handshakes.
   - `done`=1 the cycle after the 8th handshake; `active`=0.
2. Hard run: `level`=100.
   - P=2, first valid 2 cycles after capture, spacing 3.
   - 16 handshakes, index 0..15, then `done`.
3. Back-pressure: mid run, `spawn_ready` held 0 for 5 cycles at index 3.
   - `spawn_valid`/`spawn_lane`/`spawn_index` stay constant for all 5 cycles.
   - The index-4 valid arrives 5 cycles later than it would without the stall.
4. Invalid code: `level`=011 with `level_valid`=1.
   - `level_error`=1 next cycle; `spawn_valid` never asserts; `active`=0.
   - Pulsing `rst` clears `level_error`.
5. Reset mid-run: `rst` for 1 cycle while `spawn_valid`=1 at index 5.
   - Next cycle all outputs are 0.
   - With `level_valid` still high, the run restarts at index 0, and the lane sequence matches run 1 exactly.
6. Level change after capture: capture `level`=001, then switch `level` to 100.
   - Still 8 notes at spacing 9.
   - After `done`, a new `level_valid` edge is ignored: no new spawns until `rst`.

Source files
------------

// File: rtl/note_spawner.sv
// note_spawner: game-side consumer of the level selection handshake.
// Latches the difficulty when level_valid is first seen, derives a spawn
// period and note count, then issues that many spawn requests on a
// valid/ready interface, each carrying an LFSR-chosen lane.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, highest priority
//   level_valid  selection complete (level signal)
//   level        {hard, mid, easy} one-hot, sampled on the capture edge
//   spawn_ready  downstream accepts the pending spawn
//   spawn_valid  spawn request pending
//   spawn_lane   lane 0-3 of the pending note
//   spawn_index  note number 0..total-1
//   active       run in progress (WAIT or SPAWN)
//   done         all notes handed off, sticky until rst
//   level_error  invalid level code captured, sticky until rst
module note_spawner #(
    parameter logic [15:0] BASE_PERIOD = 16'd50000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_valid,
    input  logic [2:0] level,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [1:0] spawn_lane,
    output logic [4:0] spawn_index,
    output logic       active,
    output logic       done,
    output logic       level_error
);

    typedef enum logic [1:0] {IDLE, WAIT, SPAWN, DONE} state_t;

    localparam logic [15:0] P_EASY = BASE_PERIOD;
    localparam logic [15:0] P_MID  = BASE_PERIOD >> 1;
    localparam logic [15:0] P_HARD = BASE_PERIOD >> 2;

    state_t      state;
    logic [15:0] period;
    logic [15:0] timer;
    logic [4:0]  count;
    logic [4:0]  total;
    logic [7:0]  lfsr;

    logic [15:0] sel_period;
    logic [4:0]  sel_total;
    logic        sel_ok;
    logic [4:0]  count_next;

    // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Decode the level code; anything that is not exactly one-hot is rejected.
    always_comb begin
        sel_period = P_EASY;
        sel_total  = 5'd8;
        sel_ok     = 1'b1;
        case (level)
            3'b001: begin
                sel_period = P_EASY;
                sel_total  = 5'd8;
            end
            3'b010: begin
                sel_period = P_MID;
                sel_total  = 5'd12;
            end
            3'b100: begin
                sel_period = P_HARD;
                sel_total  = 5'd16;
            end
            default: sel_ok = 1'b0;
        endcase
    end

    assign count_next = count + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            period      <= 16'd0;
            timer       <= 16'd0;
            count       <= 5'd0;
            total       <= 5'd0;
            lfsr        <= LFSR_SEED;
            spawn_valid <= 1'b0;
            spawn_lane  <= 2'd0;
            spawn_index <= 5'd0;
            active      <= 1'b0;
            done        <= 1'b0;
            level_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A captured bad code locks out further captures until rst.
                    if (level_valid && !level_error) begin
                        if (sel_ok) begin
                            state  <= WAIT;
                            period <= sel_period;
                            total  <= sel_total;
                            timer  <= sel_period - 16'd1;
                            count  <= 5'd0;
                            active <= 1'b1;
                        end else begin
                            level_error <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (timer == 16'd0) begin
                        state       <= SPAWN;
                        spawn_valid <= 1'b1;
                        spawn_lane  <= lfsr[1:0];
                        spawn_index <= count;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                SPAWN: begin
                    // spawn_valid is always high here, so ready alone is the handshake.
                    // The timer is not reloaded until the handshake, so stalls push
                    // every later spawn back.
                    if (spawn_ready) begin
                        spawn_valid <= 1'b0;
                        count       <= count_next;
                        lfsr        <= lfsr_step(lfsr);
                        if (count_next == total) begin
                            state  <= DONE;
                            active <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            state <= WAIT;
                            timer <= period - 16'd1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_spawner.sv
module tb_note_spawner;

    localparam logic [15:0] BP   = 16'd8;
    localparam logic [7:0]  SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       level_valid;
    logic [2:0] level;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic [4:0] spawn_index;
    logic       active;
    logic       done;
    logic       level_error;

    always #5 clk = ~clk;

    note_spawner #(.BASE_PERIOD(BP), .LFSR_SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .level_valid (level_valid),
        .level       (level),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_index (spawn_index),
        .active      (active),
        .done        (done),
        .level_error (level_error)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // ---------------- reference model ----------------
    // Lane of note k is bits [1:0] of the seed advanced k times.
    logic [1:0] lane_seq [0:15];
    int m_phase;   // 0 idle, 1 running, 2 finished
    int m_wait;    // edges remaining before the next request appears
    int m_k;       // notes handed off so far
    int m_total;
    int m_p;
    bit m_err;
    bit m_pend;
    bit m_sync = 1'b0;

    task automatic build_lanes();
        logic [7:0] s;
        s = SEED;
        for (int i = 0; i < 16; i++) begin
            lane_seq[i] = s[1:0];
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_sync = 1'b1; m_phase = 0; m_err = 1'b0; m_pend = 1'b0;
            m_k = 0; m_wait = 0; m_total = 0; m_p = 0;
        end else if (m_sync) begin
            if (m_phase == 0) begin
                if (level_valid && !m_err) begin
                    m_p = 0;
                    if (level == 3'b001)      begin m_p = int'(BP);      m_total = 8;  end
                    else if (level == 3'b010) begin m_p = int'(BP) / 2;  m_total = 12; end
                    else if (level == 3'b100) begin m_p = int'(BP) / 4;  m_total = 16; end
                    if (m_p == 0) m_err = 1'b1;
                    else begin m_phase = 1; m_wait = m_p; m_pend = 1'b0; m_k = 0; end
                end
            end else if (m_phase == 1) begin
                if (m_pend) begin
                    if (spawn_ready) begin
                        m_k++;
                        m_pend = 1'b0;
                        if (m_k == m_total) m_phase = 2;
                        else m_wait = m_p;
                    end
                end else begin
                    m_wait--;
                    if (m_wait == 0) m_pend = 1'b1;
                end
            end
        end
    endtask

    task automatic model_compare();
        bit ok;
        int exp_lane;
        if (!m_sync) return;
        exp_lane = (m_pend && m_k < 16) ? int'(lane_seq[m_k]) : 0;
        ok = (spawn_valid === m_pend) && (active === (m_phase == 1)) &&
             (done === (m_phase == 2)) && (level_error === m_err);
        if (m_pend)
            ok = ok && (int'(spawn_lane) == exp_lane) && (int'(spawn_index) == m_k);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL model_cycle t=%0t: got v=%b lane=%0d idx=%0d act=%b done=%b err=%b, expected v=%b lane=%0d idx=%0d act=%b done=%b err=%b",
                      $time, spawn_valid, spawn_lane, spawn_index, active, done, level_error,
                      m_pend, exp_lane, m_k, (m_phase == 1), (m_phase == 2), m_err);
    endtask

    // Compare on the falling edge, advance the model on the rising edge,
    // return just after the rising edge so callers can drive and observe.
    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- run observer ----------------
    int         rises[$];
    int         idxs[$];
    logic [1:0] lanes[$];
    logic [1:0] easy_lanes[$];
    int         hs_cnt;
    int         done_t;

    // Starts right after the capture edge (t=0). Records the cycle of each
    // spawn_valid rise. Optionally stalls ready at one index, or pulses rst
    // when a given index is pending.
    task automatic run_collect(input int budget, input int stall_idx, input int stall_len,
                               input int rst_idx);
        int         t;
        int         stalled;
        bit         prev_v;
        logic [1:0] hold_lane;
        logic [4:0] hold_idx;
        t = 0; stalled = 0; prev_v = 1'b0;
        hold_lane = 2'd0; hold_idx = 5'd0;
        rises.delete(); idxs.delete(); lanes.delete();
        hs_cnt = 0; done_t = -1;
        while (t < budget) begin
            if (rst_idx >= 0 && spawn_valid && int'(spawn_index) == rst_idx) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            spawn_ready = 1'b1;
            if (spawn_valid && int'(spawn_index) == stall_idx && stalled < stall_len) begin
                if (stalled == 0) begin hold_lane = spawn_lane; hold_idx = spawn_index; end
                spawn_ready = 1'b0;
                stalled++;
            end
            if (spawn_valid && spawn_ready) hs_cnt++;
            tick();
            t++;
            if (!spawn_ready) begin
                check("stall_valid_held", int'(spawn_valid), 1);
                check("stall_lane_held", int'(spawn_lane), int'(hold_lane));
                check("stall_index_held", int'(spawn_index), int'(hold_idx));
            end
            if (spawn_valid && !prev_v) begin
                rises.push_back(t);
                idxs.push_back(int'(spawn_index));
                lanes.push_back(spawn_lane);
            end
            prev_v = spawn_valid;
            if (done) begin
                done_t = t;
                spawn_ready = 1'b1;
                return;
            end
        end
        n_total++;
        $display("FAIL run_timeout: no done within %0d cycles, got %0d spawns", budget, rises.size());
    endtask

    task automatic reset_pulse();
        rst = 1'b1; level_valid = 1'b0; level = 3'b000; spawn_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic capture(input logic [2:0] code);
        level_valid = 1'b1;
        level = code;
        tick();
    endtask

    // Checks a run collected with ready held high (except for one stall).
    task automatic check_run(input string nm, input int p, input int n,
                             input int stall_idx, input int stall_len);
        int exp_t;
        check({nm, "_count"}, rises.size(), n);
        check({nm, "_handshakes"}, hs_cnt + ((stall_len > 0) ? 0 : 0), n);
        for (int i = 0; i < rises.size() && i < n; i++) begin
            exp_t = p + (p + 1) * i + ((stall_idx >= 0 && i > stall_idx) ? stall_len : 0);
            check({nm, "_rise_time"}, rises[i], exp_t);
            check({nm, "_index"}, idxs[i], i);
            check({nm, "_lane"}, int'(lanes[i]), int'(lane_seq[i]));
        end
        exp_t = p + (p + 1) * (n - 1) + 1 + ((stall_idx >= 0) ? stall_len : 0);
        check({nm, "_done_time"}, done_t, exp_t);
        check({nm, "_done"}, int'(done), 1);
        check({nm, "_active_after"}, int'(active), 0);
        check({nm, "_valid_after"}, int'(spawn_valid), 0);
    endtask

    typedef struct {
        logic [2:0] code;
        logic       exp_err;
        logic       exp_active;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int vcnt;

        tbl[0] = '{3'b000, 1'b1, 1'b0};
        tbl[1] = '{3'b001, 1'b0, 1'b1};
        tbl[2] = '{3'b010, 1'b0, 1'b1};
        tbl[3] = '{3'b011, 1'b1, 1'b0};
        tbl[4] = '{3'b100, 1'b0, 1'b1};
        tbl[5] = '{3'b101, 1'b1, 1'b0};
        tbl[6] = '{3'b110, 1'b1, 1'b0};
        tbl[7] = '{3'b111, 1'b1, 1'b0};

        build_lanes();
        rst = 1'b1; level_valid = 1'b0; level = 3'b000; spawn_ready = 1'b0;

        // Reset state
        tick();
        check("rst_spawn_valid", int'(spawn_valid), 0);
        check("rst_spawn_lane", int'(spawn_lane), 0);
        check("rst_spawn_index", int'(spawn_index), 0);
        check("rst_active", int'(active), 0);
        check("rst_done", int'(done), 0);
        check("rst_level_error", int'(level_error), 0);
        rst = 1'b0;

        // Capture decode table
        for (int i = 0; i < 8; i++) begin
            reset_pulse();
            check("tbl_rst_clears_err", int'(level_error), 0);
            capture(tbl[i].code);
            check("tbl_err_next", int'(level_error), int'(tbl[i].exp_err));
            check("tbl_active_next", int'(active), int'(tbl[i].exp_active));
            level = 3'b001;   // a later valid code must not be captured after an error
            tick(); tick(); tick();
            check("tbl_err_held", int'(level_error), int'(tbl[i].exp_err));
            check("tbl_active_held", int'(active), int'(tbl[i].exp_active));
        end

        // Easy run
        reset_pulse();
        spawn_ready = 1'b1;
        capture(3'b001);
        check("easy_active_after_capture", int'(active), 1);
        run_collect(300, -1, 0, -1);
        check_run("easy", 8, 8, -1, 0);
        easy_lanes = lanes;

        // Hard run
        reset_pulse();
        spawn_ready = 1'b1;
        capture(3'b100);
        run_collect(300, -1, 0, -1);
        check_run("hard", 2, 16, -1, 0);

        // Mid run with a 5-cycle stall at index 3
        reset_pulse();
        spawn_ready = 1'b1;
        capture(3'b010);
        run_collect(300, 3, 5, -1);
        check_run("mid_stall", 4, 12, 3, 5);

        // Reset while index 5 is pending, then restart from the held level_valid
        reset_pulse();
        spawn_ready = 1'b1;
        capture(3'b001);
        run_collect(300, -1, 0, 5);
        check("midrst_spawns_before", rises.size(), 6);
        check("midrst_valid", int'(spawn_valid), 0);
        check("midrst_lane", int'(spawn_lane), 0);
        check("midrst_index", int'(spawn_index), 0);
        check("midrst_active", int'(active), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(level_error), 0);
        tick();   // level_valid still high: capture edge
        check("restart_active", int'(active), 1);
        run_collect(300, -1, 0, -1);
        check_run("restart", 8, 8, -1, 0);
        for (int i = 0; i < lanes.size() && i < easy_lanes.size(); i++)
            check("restart_lane_repeat", int'(lanes[i]), int'(easy_lanes[i]));

        // Level changes after capture are ignored; a new level_valid after done too
        reset_pulse();
        spawn_ready = 1'b1;
        capture(3'b001);
        level = 3'b100;
        run_collect(300, -1, 0, -1);
        check_run("lvlchg", 8, 8, -1, 0);
        level_valid = 1'b0;
        tick(); tick(); tick();
        level_valid = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (spawn_valid) vcnt++;
        end
        check("after_done_no_spawn", vcnt, 0);
        check("after_done_sticky", int'(done), 1);
        check("after_done_inactive", int'(active), 0);

        // Randomized traffic against the model
        reset_pulse();
        for (int i = 0; i < 4000; i++) begin
            spawn_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) level_valid = ~level_valid;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0) level = 3'($urandom_range(0, 7));
                else level = 3'b001 << $urandom_range(0, 2);
            end
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
